// File: rtl/echo_meter_pkg.sv
// Shared definitions for the echo range meter: per-channel FSM encoding,
// trigger timing and the "no measurement yet" reset code.
package echo_meter_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEASURE  = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

    localparam int TRIG_PERIOD = 60000;
    localparam int TRIG_LEN    = 10;
    localparam int NB_RESET    = 0;

endpackage

// File: rtl/echo_channel.sv
// One echo channel: synchroniser, edge detect, divider-free tick/unit counting,
// measurement FSM and clamped code output. Trigger generator only with ECHO_TRIG_EN.
module echo_channel
    import echo_meter_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int OUT_W   = 8,
    parameter int DIV     = 147,
    parameter int MIN_OUT = 6,
    parameter int MAX_OUT = 254,
    parameter int TIMEOUT = 38000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             echo,
    output logic [OUT_W-1:0] nb,
    output logic             valid,
`ifdef ECHO_TRIG_EN
    output logic             trig,
`endif
    output logic             timeout
);

    // DIV is assumed to be at least 2.
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(DIV - 1);
    localparam logic [OUT_W:0]   MIN_U     = (OUT_W+1)'(MIN_OUT);
    localparam logic [OUT_W:0]   MAX_U     = (OUT_W+1)'(MAX_OUT);
    localparam logic [OUT_W:0]   UNITS_SAT = (OUT_W+1)'(MAX_OUT + 1);
    localparam logic [CNT_W-1:0] TICK_END  = CNT_W'(TIMEOUT);

    logic sync1, sync2, echo_d;
    logic rise;

    state_t           state, state_nxt;
    logic [PRE_W-1:0] pre, pre_nxt;
    logic [OUT_W:0]   units, units_nxt;
    logic [CNT_W-1:0] ticks, ticks_nxt;
    logic [OUT_W-1:0] nb_nxt;
    logic             valid_nxt, timeout_nxt;

    function automatic logic [OUT_W-1:0] clamp_code(input logic [OUT_W:0] u);
        if (u < MIN_U)
            return MIN_U[OUT_W-1:0];
        else if (u > MAX_U)
            return MAX_U[OUT_W-1:0];
        else
            return u[OUT_W-1:0];
    endfunction

    // Sync flops reset high along with the history bit, so an echo that is
    // already high when reset releases never looks like a rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            echo_d <= 1'b1;
        end else begin
            sync1  <= echo;
            sync2  <= sync1;
            echo_d <= sync2;
        end
    end

    assign rise = sync2 & ~echo_d;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pre     <= '0;
            units   <= '0;
            ticks   <= '0;
            nb      <= OUT_W'(NB_RESET);
            valid   <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_nxt;
            pre     <= pre_nxt;
            units   <= units_nxt;
            ticks   <= ticks_nxt;
            nb      <= nb_nxt;
            valid   <= valid_nxt;
            timeout <= timeout_nxt;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // through the case statement can leave a latch behind.
    always_comb begin
        state_nxt   = state;
        pre_nxt     = pre;
        units_nxt   = units;
        ticks_nxt   = ticks;
        nb_nxt      = nb;
        valid_nxt   = 1'b0;
        timeout_nxt = timeout;

        case (state)
            IDLE: begin
                // The rising-edge cycle is itself the first high tick.
                if (rise) begin
                    pre_nxt   = PRE_W'(1);
                    units_nxt = '0;
                    ticks_nxt = CNT_W'(1);
                    state_nxt = MEASURE;
                end
            end
            MEASURE: begin
                if (!sync2) begin
                    nb_nxt      = clamp_code(units);
                    valid_nxt   = 1'b1;
                    timeout_nxt = 1'b0;
                    state_nxt   = IDLE;
                end else if (ticks == TICK_END) begin
                    nb_nxt      = MAX_U[OUT_W-1:0];
                    valid_nxt   = 1'b1;
                    timeout_nxt = 1'b1;
                    state_nxt   = WAIT_LOW;
                end else begin
                    ticks_nxt = ticks + 1'b1;
                    if (pre == PRE_LAST) begin
                        pre_nxt = '0;
                        if (units != UNITS_SAT)
                            units_nxt = units + 1'b1;
                    end else begin
                        pre_nxt = pre + 1'b1;
                    end
                end
            end
            WAIT_LOW: begin
                if (!sync2)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef ECHO_TRIG_EN
    localparam int TP_W = $clog2(TRIG_PERIOD);

    logic [TP_W-1:0] per_cnt;

    // The period counter free-runs; only the pulse is gated by the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_cnt <= '0;
            trig    <= 1'b0;
        end else begin
            per_cnt <= (per_cnt == TP_W'(TRIG_PERIOD - 1)) ? '0 : per_cnt + 1'b1;
            trig    <= (per_cnt < TP_W'(TRIG_LEN)) && (state == IDLE);
        end
    end
`endif

endmodule

// File: rtl/echo_range_meter.sv
// Multi-channel ultrasonic echo-width meter: N_CH independent echo_channel
// instances with packed outputs. Define ECHO_TRIG_EN to add per-channel Trig outputs.
module echo_range_meter
    import echo_meter_pkg::*;
#(
    parameter int N_CH    = 2,
    parameter int CNT_W   = 32,
    parameter int OUT_W   = 8,
    parameter int DIV     = 147,
    parameter int MIN_OUT = 6,
    parameter int MAX_OUT = 254,
    parameter int TIMEOUT = 38000
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [N_CH-1:0]       Mesure,
    output logic [N_CH*OUT_W-1:0] Nb,
    output logic [N_CH-1:0]       Valid,
`ifdef ECHO_TRIG_EN
    output logic [N_CH-1:0]       Trig,
`endif
    output logic [N_CH-1:0]       Timeout
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        echo_channel #(
            .CNT_W   (CNT_W),
            .OUT_W   (OUT_W),
            .DIV     (DIV),
            .MIN_OUT (MIN_OUT),
            .MAX_OUT (MAX_OUT),
            .TIMEOUT (TIMEOUT)
        ) u_ch (
            .clk     (Clk),
            .rst     (Rst),
            .echo    (Mesure[i]),
            .nb      (Nb[i*OUT_W +: OUT_W]),
            .valid   (Valid[i]),
`ifdef ECHO_TRIG_EN
            .trig    (Trig[i]),
`endif
            .timeout (Timeout[i])
        );
    end

endmodule

// File: tb/tb_echo_range_meter.sv
// Directed bench for echo_range_meter at default parameters (Clk = 1 MHz):
// a table of single-pulse vectors plus hand-written timeout, tie, overlap and reset sequences.
`timescale 1ns/1ps
module tb_echo_range_meter;

    logic        Clk;
    logic        Rst;
    logic [1:0]  Mesure;
    logic [15:0] Nb;
    logic [1:0]  Valid;
    logic [1:0]  Timeout;
`ifdef ECHO_TRIG_EN
    logic [1:0]  Trig;
`endif

    int checks = 0;
    int errors = 0;

    echo_range_meter dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .Mesure  (Mesure),
        .Nb      (Nb),
        .Valid   (Valid),
`ifdef ECHO_TRIG_EN
        .Trig    (Trig),
`endif
        .Timeout (Timeout)
    );

    initial Clk = 1'b0;
    always #500 Clk = ~Clk;

    typedef struct {
        int         ch;
        int         width;
        logic [7:0] nb;
        logic       to;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Raw echo high for exactly `width` rising edges, then check the
    // 3-cycle Valid latency, the one-cycle strobe, the code and the flag.
    task automatic pulse_check(input int ch, input int width, input logic [7:0] exp_nb,
                               input logic exp_to, input string name);
        @(posedge Clk); #1 Mesure[ch] = 1'b1;
        repeat (width) @(posedge Clk);
        #1 Mesure[ch] = 1'b0;
        repeat (2) @(posedge Clk);
        #1 check({name, "_valid_early"}, 32'(Valid[ch]), 32'd0);
        @(posedge Clk);
        #1 check({name, "_valid"}, 32'(Valid[ch]), 32'd1);
        check({name, "_nb"}, 32'(Nb[ch*8 +: 8]), 32'(exp_nb));
        check({name, "_timeout"}, 32'(Timeout[ch]), 32'(exp_to));
        @(posedge Clk);
        #1 check({name, "_valid_once"}, 32'(Valid[ch]), 32'd0);
        repeat (3) @(posedge Clk);
    endtask

    initial begin
        #100_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[9];
        int   n;
        int   extra;

        vecs[0] = '{ch: 0, width: 1470, nb: 8'd10, to: 1'b0};
        vecs[1] = '{ch: 0, width: 1469, nb: 8'd9,  to: 1'b0};
        vecs[2] = '{ch: 0, width: 300,  nb: 8'd6,  to: 1'b0};
        vecs[3] = '{ch: 1, width: 881,  nb: 8'd6,  to: 1'b0};
        vecs[4] = '{ch: 1, width: 882,  nb: 8'd6,  to: 1'b0};
        vecs[5] = '{ch: 0, width: 1,    nb: 8'd6,  to: 1'b0};
        vecs[6] = '{ch: 1, width: 1617, nb: 8'd11, to: 1'b0};
        vecs[7] = '{ch: 0, width: 2058, nb: 8'd14, to: 1'b0};
        vecs[8] = '{ch: 1, width: 1470, nb: 8'd10, to: 1'b0};

        Rst    = 1'b1;
        Mesure = 2'b00;
        repeat (3) @(posedge Clk);
        #1 check("rst_nb", 32'(Nb), 32'd0);
        check("rst_valid", 32'(Valid), 32'd0);
        check("rst_timeout", 32'(Timeout), 32'd0);
        Rst = 1'b0;
        repeat (4) @(posedge Clk);
        #1 check("idle_valid", 32'(Valid), 32'd0);

        for (int i = 0; i < 9; i++)
            pulse_check(vecs[i].ch, vecs[i].width, vecs[i].nb, vecs[i].to,
                        $sformatf("vec%0d", i));

        // ch0: 38000-tick pulse (fall and timeout coincide, fall wins);
        // ch1: 40000-tick pulse times out; both Valids land on the same edge.
        fork
            pulse_check(0, 38000, 8'd254, 1'b0, "tie");
            begin
                @(posedge Clk); #1 Mesure[1] = 1'b1;
                n = 0;
                while (n < 38100 && Valid[1] !== 1'b1) begin
                    @(posedge Clk); #1 n++;
                end
                check("to_latency", 32'(n), 32'd38003);
                check("to_nb", 32'(Nb[15:8]), 32'd254);
                check("to_flag", 32'(Timeout[1]), 32'd1);
                repeat (40000 - n) @(posedge Clk);
                #1 Mesure[1] = 1'b0;
                extra = 0;
                repeat (8) begin
                    @(posedge Clk); #1 if (Valid[1]) extra++;
                end
                check("to_no_second_valid", 32'(extra), 32'd0);
            end
        join
        check("tie_to_nb_both", 32'(Nb), {16'd0, 8'd254, 8'd254});
        check("tie_to_flags", 32'(Timeout), 32'd2);

        pulse_check(1, 1470, 8'd10, 1'b0, "after_to");

        // Both channels fall on the same cycle: 2940 ticks on ch1, 1470 on ch0.
        fork
            begin
                @(posedge Clk); #1 Mesure[1] = 1'b1;
                repeat (2940) @(posedge Clk);
                #1 Mesure[1] = 1'b0;
            end
            begin
                @(posedge Clk);
                repeat (1470) @(posedge Clk);
                #1 Mesure[0] = 1'b1;
                repeat (1470) @(posedge Clk);
                #1 Mesure[0] = 1'b0;
            end
        join
        repeat (2) @(posedge Clk);
        #1 check("dual_valid_early", 32'(Valid), 32'd0);
        @(posedge Clk);
        #1 check("dual_valid", 32'(Valid), 32'd3);
        check("dual_nb", 32'(Nb), {16'd0, 8'd20, 8'd10});
        repeat (4) @(posedge Clk);

        // Reset in the middle of a measurement; echo stays high across release.
        @(posedge Clk); #1 Mesure[0] = 1'b1;
        repeat (700) @(posedge Clk);
        #1 Rst = 1'b1;
        #10 check("midrst_nb", 32'(Nb), 32'd0);
        check("midrst_valid", 32'(Valid), 32'd0);
        @(posedge Clk);
        #1 Rst = 1'b0;
        repeat (800) @(posedge Clk);
        #1 Mesure[0] = 1'b0;
        extra = 0;
        repeat (8) begin
            @(posedge Clk); #1 if (Valid != 2'b00) extra++;
        end
        check("midrst_no_valid", 32'(extra), 32'd0);
        check("midrst_nb_hold", 32'(Nb), 32'd0);
        pulse_check(0, 1470, 8'd10, 1'b0, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
